regfile_access_ctrl: RTL and testbench

// Owns all access to the 32x32 integer register file. After reset it sequences
// a zero-fill sweep of every register, then gives the core the read/write

---
 rtl/regfile_access_ctrl.sv | 122 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: zero-fills the register file after reset,
// then arbitrates core read/write ports against single-cycle debug accesses.
module regfile_access_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_core_rs1_addr,
  input  logic [ADDR_W-1:0] i_core_rs2_addr,
  input  logic              i_core_wr_en,
  input  logic [ADDR_W-1:0] i_core_wr_addr,
  input  logic [DATA_W-1:0] i_core_wr_data,
  output logic              o_core_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic [ADDR_W-1:0] o_rf_rs1_addr,
  output logic [ADDR_W-1:0] o_rf_rs2_addr,
  output logic [ADDR_W-1:0] o_rf_rd_addr,
  output logic [DATA_W-1:0] o_rf_rd_data,
  output logic              o_rf_rd_wren,
  input  logic [DATA_W-1:0] i_rf_rs1_data,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DBG  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    done_d  = done_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_REG) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (i_dbg_req) state_d = S_DBG;
      end
      S_DBG: begin
        rdata_d = i_rf_rs1_data;
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Port steering decoded from the registered state; core owns the ports by default
  always_comb begin
    o_core_stall  = 1'b0;
    o_rf_rs1_addr = i_core_rs1_addr;
    o_rf_rs2_addr = i_core_rs2_addr;
    o_rf_rd_addr  = i_core_wr_addr;
    o_rf_rd_data  = i_core_wr_data;
    o_rf_rd_wren  = i_core_wr_en && (i_core_wr_addr != '0);
    case (state_q)
      S_INIT: begin
        o_core_stall = 1'b1;
        o_rf_rd_wren = 1'b1;
        o_rf_rd_addr = cnt_q;
        o_rf_rd_data = '0;
      end
      S_DBG: begin
        o_core_stall  = 1'b1;
        o_rf_rs1_addr = i_dbg_addr;
        o_rf_rd_addr  = i_dbg_addr;
        o_rf_rd_data  = i_dbg_wdata;
        o_rf_rd_wren  = i_dbg_we && (i_dbg_addr != '0);
      end
      default: ;
    endcase
  end

  assign o_dbg_ack   = ack_q;
  assign o_dbg_rdata = rdata_q;
  assign o_init_done = done_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file plus a reference
// array of expected register contents driven by directed and random accesses.
module tb_regfile_access_ctrl;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_core_rs1_addr, i_core_rs2_addr, i_core_wr_addr;
  logic          i_core_wr_en;
  logic [DW-1:0] i_core_wr_data;
  logic          o_core_stall;
  logic          i_dbg_req, i_dbg_we;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] i_dbg_wdata;
  logic          o_dbg_ack;
  logic [DW-1:0] o_dbg_rdata;
  logic [AW-1:0] o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr;
  logic [DW-1:0] o_rf_rd_data;
  logic          o_rf_rd_wren;
  logic [DW-1:0] i_rf_rs1_data;
  logic          o_init_done;

  always #5 i_clk = ~i_clk;

  regfile_access_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_core_rs1_addr(i_core_rs1_addr), .i_core_rs2_addr(i_core_rs2_addr),
    .i_core_wr_en(i_core_wr_en), .i_core_wr_addr(i_core_wr_addr),
    .i_core_wr_data(i_core_wr_data), .o_core_stall(o_core_stall),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd_data(o_rf_rd_data),
    .o_rf_rd_wren(o_rf_rd_wren), .i_rf_rs1_data(i_rf_rs1_data),
    .o_init_done(o_init_done)
  );

  // Behavioural register file; seeded with garbage so the zero-fill is observable
  logic [DW-1:0] rf [NR];
  logic          seed;
  assign i_rf_rs1_data = rf[o_rf_rs1_addr];
  always @(posedge i_clk) begin
    if (seed) begin
      for (int i = 0; i < int'(NR); i++) rf[i] <= $urandom();
    end else if (o_rf_rd_wren) begin
      rf[o_rf_rd_addr] <= o_rf_rd_data;
    end
  end

  logic [DW-1:0] ref_regs [NR];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_regs(input string tag);
    int bad = 0;
    for (int i = 0; i < int'(NR); i++) if (rf[i] !== ref_regs[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < int'(NR); i++) ref_regs[i] = '0;
  endtask

  task automatic core_rand();
    i_core_rs1_addr = AW'($urandom_range(0, NR - 1));
    i_core_rs2_addr = AW'($urandom_range(0, NR - 1));
    i_core_wr_addr  = AW'($urandom_range(0, NR - 1));
    i_core_wr_data  = $urandom();
    i_core_wr_en    = 1'($urandom_range(0, 1));
  endtask

  // Checks the core-owned port behaviour and commits the expected write
  task automatic run_cycle(input string tag);
    logic exp_we;
    settle();
    exp_we = i_core_wr_en && (i_core_wr_addr != 0);
    chk({tag, "_stall"}, 32'(o_core_stall), 32'd0);
    chk({tag, "_rs1"}, 32'(o_rf_rs1_addr), 32'(i_core_rs1_addr));
    chk({tag, "_rs2"}, 32'(o_rf_rs2_addr), 32'(i_core_rs2_addr));
    chk({tag, "_wren"}, 32'(o_rf_rd_wren), 32'(exp_we));
    cyc();
    if (exp_we) ref_regs[i_core_wr_addr] = i_core_wr_data;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < int'(NR); k++) begin
      chk({tag, "_wren"}, 32'(o_rf_rd_wren), 32'd1);
      chk({tag, "_addr"}, 32'(o_rf_rd_addr), 32'(k));
      chk({tag, "_data"}, o_rf_rd_data, 32'd0);
      chk({tag, "_stall"}, 32'(o_core_stall), 32'd1);
      chk({tag, "_done"}, 32'(o_init_done), 32'd0);
      chk({tag, "_ack"}, 32'(o_dbg_ack), 32'd0);
      cyc();
    end
    clear_ref();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] da;
    logic [DW-1:0] dd, old;
    logic          dw;
    seed = 1'b1; i_rst = 1'b0;
    i_core_rs1_addr = '0; i_core_rs2_addr = '0; i_core_wr_addr = '0;
    i_core_wr_en = 1'b0; i_core_wr_data = '0;
    i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    cyc(); seed = 1'b0; cyc();
    chk("rst_done", 32'(o_init_done), 32'd0);
    chk("rst_ack", 32'(o_dbg_ack), 32'd0);
    chk("rst_rdata", o_dbg_rdata, 32'd0);
    chk("rst_stall", 32'(o_core_stall), 32'd1);

    i_rst = 1'b1;
    sweep("init");
    chk("init_done", 32'(o_init_done), 32'd1);
    chk("init_run_stall", 32'(o_core_stall), 32'd0);
    check_regs("zero_fill");

    // Core write x5 and read it back; x0 write suppressed
    i_core_wr_en = 1'b1; i_core_wr_addr = 5'd5; i_core_wr_data = 32'hDEADBEEF;
    i_core_rs1_addr = 5'd5;
    run_cycle("wr_x5");
    i_core_wr_en = 1'b0; settle();
    chk("rd_x5", i_rf_rs1_data, 32'hDEADBEEF);
    i_core_wr_en = 1'b1; i_core_wr_addr = 5'd0; i_core_wr_data = 32'h1234;
    i_core_rs1_addr = 5'd0;
    run_cycle("wr_x0");
    i_core_wr_en = 1'b0; settle();
    chk("rd_x0", i_rf_rs1_data, 32'd0);

    // Debug read x5; core write in the request cycle commits, DBG-cycle write masked
    dd = $urandom();
    i_core_wr_en = 1'b1; i_core_wr_addr = 5'd3; i_core_wr_data = dd;
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd5;
    run_cycle("dbgrd_req");
    i_core_wr_addr = 5'd9; i_core_wr_data = 32'h11; settle();
    chk("dbgrd_stall", 32'(o_core_stall), 32'd1);
    chk("dbgrd_wren", 32'(o_rf_rd_wren), 32'd0);
    chk("dbgrd_rs1", 32'(o_rf_rs1_addr), 32'd5);
    chk("dbgrd_noack", 32'(o_dbg_ack), 32'd0);
    cyc();
    chk("dbgrd_ack", 32'(o_dbg_ack), 32'd1);
    chk("dbgrd_rdata", o_dbg_rdata, 32'hDEADBEEF);
    chk("dbgrd_ack_stall", 32'(o_core_stall), 32'd0);
    i_dbg_req = 1'b0; i_core_wr_en = 1'b0;
    cyc();
    chk("dbgrd_ack_drop", 32'(o_dbg_ack), 32'd0);
    chk("dbgrd_hold", o_dbg_rdata, 32'hDEADBEEF);
    check_regs("dbgrd_regs");

    // Debug write x7 while the core tries x9 in the DBG cycle
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd7; i_dbg_wdata = 32'hA5A5A5A5;
    old = ref_regs[7];
    run_cycle("dbgwr_req");
    i_core_wr_en = 1'b1; i_core_wr_addr = 5'd9; i_core_wr_data = 32'h11; settle();
    chk("dbgwr_stall", 32'(o_core_stall), 32'd1);
    chk("dbgwr_wren", 32'(o_rf_rd_wren), 32'd1);
    chk("dbgwr_addr", 32'(o_rf_rd_addr), 32'd7);
    chk("dbgwr_data", o_rf_rd_data, 32'hA5A5A5A5);
    cyc(); ref_regs[7] = 32'hA5A5A5A5;
    chk("dbgwr_ack", 32'(o_dbg_ack), 32'd1);
    chk("dbgwr_rdata", o_dbg_rdata, old);
    i_dbg_req = 1'b0; i_core_wr_en = 1'b0;
    cyc();
    check_regs("dbgwr_regs");

    // Debug write to x0 is suppressed but still acked
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd0; i_dbg_wdata = 32'hFFFF0000;
    run_cycle("dbgx0_req");
    chk("dbgx0_wren", 32'(o_rf_rd_wren), 32'd0);
    cyc();
    chk("dbgx0_ack", 32'(o_dbg_ack), 32'd1);
    i_dbg_req = 1'b0;
    cyc();
    check_regs("dbgx0_regs");

    for (int n = 0; n < 24; n++) begin
      core_rand();
      run_cycle("rnd_core");
    end
    i_core_wr_en = 1'b0;
    check_regs("rnd_core_regs");

    // Random debug accesses mixed with random core traffic
    for (int n = 0; n < 12; n++) begin
      core_rand();
      dw = 1'($urandom_range(0, 1)); da = AW'($urandom_range(0, NR - 1)); dd = $urandom();
      i_dbg_req = 1'b1; i_dbg_we = dw; i_dbg_addr = da; i_dbg_wdata = dd;
      run_cycle("rnd_dbg_req");
      old = ref_regs[da];
      core_rand(); settle();
      chk("rnd_dbg_stall", 32'(o_core_stall), 32'd1);
      chk("rnd_dbg_wren", 32'(o_rf_rd_wren), 32'(dw && (da != 0)));
      cyc();
      if (dw && (da != 0)) ref_regs[da] = dd;
      chk("rnd_dbg_ack", 32'(o_dbg_ack), 32'd1);
      chk("rnd_dbg_rdata", o_dbg_rdata, old);
      i_dbg_req = 1'b0; i_core_wr_en = 1'b0;
      cyc();
      chk("rnd_dbg_ack_drop", 32'(o_dbg_ack), 32'd0);
    end
    check_regs("rnd_dbg_regs");

    // Reset during DBG: no ack, full re-sweep, held request served afterwards
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd5;
    run_cycle("rstdbg_req");
    i_rst = 1'b0;
    cyc();
    chk("rstdbg_noack", 32'(o_dbg_ack), 32'd0);
    chk("rstdbg_stall", 32'(o_core_stall), 32'd1);
    chk("rstdbg_done", 32'(o_init_done), 32'd0);
    chk("rstdbg_rdata", o_dbg_rdata, 32'd0);
    i_rst = 1'b1;
    sweep("resweep");
    chk("resweep_done", 32'(o_init_done), 32'd1);
    chk("resweep_run_stall", 32'(o_core_stall), 32'd0);
    cyc();
    chk("held_dbg_stall", 32'(o_core_stall), 32'd1);
    chk("held_dbg_rs1", 32'(o_rf_rs1_addr), 32'd5);
    cyc();
    chk("held_dbg_ack", 32'(o_dbg_ack), 32'd1);
    chk("held_dbg_rdata", o_dbg_rdata, 32'd0);
    i_dbg_req = 1'b0;
    cyc();
    check_regs("resweep_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
